// File: rtl/dram_bist_ctrl.sv
// -----------------------------------------------------------------------------
// dram_bist_ctrl
// Built-in self test sequencer for a 2**AW x DW distributed-RAM array (one
// RAM64X1S per data bit, shared address and WE). A start pulse writes a
// deterministic address-derived pattern to every word, reads every word back,
// and reports pass/fail, the number of mismatching words and the first failing
// address.
//
// Optional feature macro: DRAM_BIST_INV_PASS_EN
//   When defined, a second write/read sweep with every pattern bit complemented
//   follows the normal sweep, so stuck-at faults are caught in both polarities.
//
// Ports
//   clk            in   RAM write clock; all state changes on its rising edge
//   rst_n          in   asynchronous active-low reset
//   start          in   one-cycle request, honoured only in IDLE or DONE
//   ram_addr       out  AW   shared address of all RAM instances
//   ram_d          out  DW   bit i drives D of RAM instance i
//   ram_we         out  1    shared write enable (registered, glitch-free)
//   ram_q          in   DW   bit i from O of RAM instance i (async read)
//   busy           out  1    high while writing or reading
//   done           out  1    high in DONE
//   pass           out  1    done with no mismatches
//   err_count      out  AW+2 mismatching words over all sweeps
//   first_err_addr out  AW   address of earliest mismatch (valid if err_count != 0)
// -----------------------------------------------------------------------------
module dram_bist_ctrl #(
    parameter int unsigned    AW   = 6,
    parameter int unsigned    DW   = 4,
    parameter logic [DW-1:0]  SEED = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [AW-1:0]   ram_addr,
    output logic [DW-1:0]   ram_d,
    output logic            ram_we,
    input  logic [DW-1:0]   ram_q,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [AW+1:0]   err_count,
    output logic [AW-1:0]   first_err_addr
);

    localparam int unsigned CW = AW + 2;

`ifdef DRAM_BIST_INV_PASS_EN
    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_READ, S_DONE, S_WRITE_INV, S_READ_INV
    } state_e;
`else
    typedef enum logic [1:0] {
        S_IDLE, S_WRITE, S_READ, S_DONE
    } state_e;
`endif

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            we_q, we_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [CW-1:0]   err_q, err_d;
    logic [AW-1:0]   fea_q, fea_d;

    logic            rd_inv;
    logic            wr_inv_next;
    logic            mismatch;
    logic            last_addr;

    // Expected word: low DW bits of the (zero-extended) address, seeded, optionally complemented.
    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a, input logic inv);
        logic [AW+DW-1:0] a_ext;
        a_ext = (AW+DW)'(a);
        return a_ext[DW-1:0] ^ SEED ^ {DW{inv}};
    endfunction

`ifdef DRAM_BIST_INV_PASS_EN
    assign rd_inv      = (state_q == S_READ_INV);
    assign wr_inv_next = (state_d == S_WRITE_INV);
`else
    assign rd_inv      = 1'b0;
    assign wr_inv_next = 1'b0;
`endif

    assign last_addr = (addr_q == '1);
    // Asynchronous RAM read: compare in the same cycle the address is presented.
    assign mismatch  = (ram_q != pattern(addr_q, rd_inv));

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fea_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fea_q   <= fea_d;
        end
    end

    // Next-state, counters and output decode.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        err_d   = err_q;
        fea_d   = fea_q;
        we_d    = 1'b0;
        wdata_d = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pass_d  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    err_d   = '0;
                    fea_d   = '0;
                    addr_d  = '0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                addr_d = addr_q + AW'(1);
                if (last_addr) begin
                    state_d = S_READ;
                end
            end
`ifdef DRAM_BIST_INV_PASS_EN
            S_WRITE_INV: begin
                addr_d = addr_q + AW'(1);
                if (last_addr) begin
                    state_d = S_READ_INV;
                end
            end
            S_READ, S_READ_INV: begin
`else
            S_READ: begin
`endif
                addr_d = addr_q + AW'(1);
                if (mismatch) begin
                    err_d = err_q + CW'(1);
                    if (err_q == '0) begin
                        fea_d = addr_q;
                    end
                end
                if (last_addr) begin
`ifdef DRAM_BIST_INV_PASS_EN
                    state_d = rd_inv ? S_DONE : S_WRITE_INV;
`else
                    state_d = S_DONE;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state and registered, so WE never glitches.
`ifdef DRAM_BIST_INV_PASS_EN
        we_d   = (state_d == S_WRITE) || (state_d == S_WRITE_INV);
        busy_d = we_d || (state_d == S_READ) || (state_d == S_READ_INV);
`else
        we_d   = (state_d == S_WRITE);
        busy_d = we_d || (state_d == S_READ);
`endif
        wdata_d = we_d ? pattern(addr_d, wr_inv_next) : '0;
        done_d  = (state_d == S_DONE);
        pass_d  = done_d && (err_d == '0);
    end

    assign ram_addr       = addr_q;
    assign ram_d          = wdata_q;
    assign ram_we         = we_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = fea_q;

endmodule
